// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and load results onto the single register-file write port
// and keeps a scoreboard of destination registers with loads still in flight.
module wb_arbiter #(
  parameter int STARVE_LIM = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  chk_rs1,
  input  logic [4:0]  chk_rs2,
  input  logic [4:0]  chk_rd,
  output logic        hazard,
  output logic [31:0] busy_mask,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  localparam int CW = $clog2(STARVE_LIM + 2);

  logic [CW-1:0] r_starve_cnt;
  logic          r_rf_wen;
  logic [4:0]    r_rf_waddr;
  logic [31:0]   r_rf_wdata;
  logic          r_src_mem;
  logic [31:0]   r_busy;

  logic          w_force_alu;
  logic          w_alu_xfer;
  logic          w_mem_xfer;
  logic [4:0]    w_sel_rd;
  logic [31:0]   w_sel_data;
  logic [CW-1:0] w_starve_next;
  logic [31:0]   w_busy_next;

  // Loads win by default; a starved ALU gets exactly one forced grant.
  assign w_force_alu = (r_starve_cnt == CW'(STARVE_LIM));
  assign alu_ready   = (w_force_alu && alu_valid) ? 1'b1 : !mem_valid;
  assign mem_ready   = !(w_force_alu && alu_valid);
  assign w_alu_xfer  = alu_valid && alu_ready;
  assign w_mem_xfer  = mem_valid && mem_ready;

  assign w_sel_rd   = w_mem_xfer ? mem_rd   : alu_rd;
  assign w_sel_data = w_mem_xfer ? mem_data : alu_data;

  always_comb begin
    w_starve_next = r_starve_cnt;
    if (!alu_valid || w_alu_xfer) begin
      w_starve_next = '0;
    end else if (r_starve_cnt != CW'(STARVE_LIM)) begin
      w_starve_next = r_starve_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
      r_rf_wen     <= 1'b0;
      r_rf_waddr   <= '0;
      r_rf_wdata   <= '0;
      r_src_mem    <= 1'b0;
    end else begin
      r_starve_cnt <= w_starve_next;
      if (w_mem_xfer || w_alu_xfer) begin
        r_rf_wen   <= (w_sel_rd != 5'd0);
        r_rf_waddr <= w_sel_rd;
        r_rf_wdata <= w_sel_data;
        r_src_mem  <= w_mem_xfer;
      end else begin
        r_rf_wen   <= 1'b0;
      end
    end
  end

  // Clear lands on the register-file commit edge; a same-edge reissue keeps the bit set.
  assign w_busy_next[0] = 1'b0;
  genvar gi;
  generate
    for (gi = 1; gi < 32; gi++) begin : g_busy
      logic w_set;
      logic w_clr;
      assign w_set = issue_valid && (issue_rd == 5'(gi));
      assign w_clr = r_rf_wen && r_src_mem && (r_rf_waddr == 5'(gi));
      assign w_busy_next[gi] = w_set | (r_busy[gi] & ~w_clr);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  assign hazard    = r_busy[chk_rs1] | r_busy[chk_rs2] | r_busy[chk_rd];
  assign busy_mask = r_busy;
  assign rf_wen    = r_rf_wen;
  assign rf_waddr  = r_rf_waddr;
  assign rf_wdata  = r_rf_wdata;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected register-file writes are queued as stimulus is
// issued and a negedge monitor pops and compares them whenever rf_wen is seen.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, mem_valid, issue_valid;
  logic        alu_ready, mem_ready, hazard, rf_wen;
  logic [4:0]  alu_rd, mem_rd, issue_rd, chk_rs1, chk_rs2, chk_rd, rf_waddr;
  logic [31:0] alu_data, mem_data, busy_mask, rf_wdata;

  int errors = 0;
  int checks = 0;
  logic [36:0] exp_q[$];

  wb_arbiter #(.STARVE_LIM(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
    .hazard(hazard), .busy_mask(busy_mask),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Monitor: every observed write must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rf_wen !== 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got waddr=%0d wdata=%h expected no write", rf_waddr, rf_wdata);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        check("wr_addr", {27'd0, rf_waddr}, {27'd0, e[36:32]});
        check("wr_data", rf_wdata, e[31:0]);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    alu_valid = 0; mem_valid = 0; issue_valid = 0;
    alu_rd = 0; mem_rd = 0; issue_rd = 0; chk_rs1 = 0; chk_rs2 = 0; chk_rd = 0;
    alu_data = 0; mem_data = 0;

    // Reset state
    #2;
    check("rst_rf_wen", {31'd0, rf_wen}, 32'd0);
    check("rst_waddr", {27'd0, rf_waddr}, 32'd0);
    check("rst_wdata", rf_wdata, 32'd0);
    check("rst_busy", busy_mask, 32'd0);
    check("rst_mem_ready", {31'd0, mem_ready}, 32'd1);
    check("rst_alu_ready_idle", {31'd0, alu_ready}, 32'd1);
    check("rst_hazard", {31'd0, hazard}, 32'd0);
    mem_valid = 1; settle();
    check("rst_alu_ready_memv", {31'd0, alu_ready}, 32'd0);
    mem_valid = 0;
    #8 rst_n = 1'b1;
    step();

    // ALU only
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF; settle();
    check("alu_only_ready", {31'd0, alu_ready}, 32'd1);
    exp_q.push_back({5'd5, 32'hDEADBEEF});
    step();
    alu_valid = 0;
    check("alu_only_wen_n1", {31'd0, rf_wen}, 32'd1);
    step();
    check("alu_only_wen_n2", {31'd0, rf_wen}, 32'd0);

    // Contention: expect mem, mem, alu, mem
    mem_valid = 1; mem_rd = 10; mem_data = 32'h1000_0000;
    alu_valid = 1; alu_rd = 11; alu_data = 32'hA000_0000; settle();
    check("cont1_mem_ready", {31'd0, mem_ready}, 32'd1);
    check("cont1_alu_ready", {31'd0, alu_ready}, 32'd0);
    exp_q.push_back({5'd10, 32'h1000_0000});
    step();
    mem_rd = 12; mem_data = 32'h1000_0001; settle();
    check("cont2_mem_ready", {31'd0, mem_ready}, 32'd1);
    check("cont2_alu_ready", {31'd0, alu_ready}, 32'd0);
    exp_q.push_back({5'd12, 32'h1000_0001});
    step();
    mem_rd = 13; mem_data = 32'h1000_0002; settle();
    check("cont3_mem_ready", {31'd0, mem_ready}, 32'd0);
    check("cont3_alu_ready", {31'd0, alu_ready}, 32'd1);
    exp_q.push_back({5'd11, 32'hA000_0000});
    step();
    alu_rd = 14; alu_data = 32'hA000_0001; settle();
    check("cont4_mem_ready", {31'd0, mem_ready}, 32'd1);
    check("cont4_alu_ready", {31'd0, alu_ready}, 32'd0);
    exp_q.push_back({5'd13, 32'h1000_0002});
    step();
    mem_valid = 0; alu_valid = 0;
    step();

    // Scoreboard on x7
    issue_valid = 1; issue_rd = 7;
    step();
    issue_valid = 0; chk_rs1 = 7; settle();
    check("sb7_hazard_set", {31'd0, hazard}, 32'd1);
    check("sb7_busy_set", busy_mask, 32'h0000_0080);
    mem_valid = 1; mem_rd = 7; mem_data = 32'h0000_0077;
    exp_q.push_back({5'd7, 32'h0000_0077});
    step();
    mem_valid = 0; settle();
    check("sb7_hazard_commit_cycle", {31'd0, hazard}, 32'd1);
    step();
    check("sb7_hazard_cleared", {31'd0, hazard}, 32'd0);
    issue_valid = 1; issue_rd = 7;
    step();
    issue_valid = 0;
    alu_valid = 1; alu_rd = 7; alu_data = 32'h0000_0707;
    exp_q.push_back({5'd7, 32'h0000_0707});
    step();
    alu_valid = 0;
    step();
    check("sb7_alu_keeps_busy", busy_mask, 32'h0000_0080);
    chk_rs1 = 0; chk_rs2 = 7; settle();
    check("sb7_hazard_rs2", {31'd0, hazard}, 32'd1);
    chk_rs2 = 0;
    mem_valid = 1; mem_rd = 7; mem_data = 32'h0000_0078;
    exp_q.push_back({5'd7, 32'h0000_0078});
    step();
    mem_valid = 0;
    step();
    check("sb7_cleared_again", busy_mask, 32'd0);

    // Simultaneous set and clear of x9
    issue_valid = 1; issue_rd = 9;
    step();
    issue_valid = 0;
    mem_valid = 1; mem_rd = 9; mem_data = 32'h0000_0099;
    exp_q.push_back({5'd9, 32'h0000_0099});
    step();
    mem_valid = 0; issue_valid = 1; issue_rd = 9;
    step();
    issue_valid = 0; chk_rd = 9; settle();
    check("sb9_set_wins", busy_mask, 32'h0000_0200);
    check("sb9_hazard_rd", {31'd0, hazard}, 32'd1);
    chk_rd = 0;
    mem_valid = 1; mem_rd = 9; mem_data = 32'h0000_009A;
    exp_q.push_back({5'd9, 32'h0000_009A});
    step();
    mem_valid = 0;
    step();
    check("sb9_cleared", busy_mask, 32'd0);

    // x0 writes and issue
    alu_valid = 1; alu_rd = 0; alu_data = 32'h1234_5678; settle();
    check("x0_alu_ready", {31'd0, alu_ready}, 32'd1);
    step();
    alu_valid = 0;
    check("x0_alu_no_wen", {31'd0, rf_wen}, 32'd0);
    mem_valid = 1; mem_rd = 0; mem_data = 32'h8765_4321;
    issue_valid = 1; issue_rd = 0; settle();
    check("x0_mem_ready", {31'd0, mem_ready}, 32'd1);
    step();
    mem_valid = 0; issue_valid = 0;
    check("x0_mem_no_wen", {31'd0, rf_wen}, 32'd0);
    step();
    check("x0_busy", busy_mask, 32'd0);
    check("x0_hazard", {31'd0, hazard}, 32'd0);

    // Reset mid-operation with a pending write
    issue_valid = 1; issue_rd = 4;
    alu_valid = 1; alu_rd = 3; alu_data = 32'hCAFE_F00D;
    step();
    issue_valid = 0; alu_valid = 0; settle();
    check("mid_pre_wen", {31'd0, rf_wen}, 32'd1);
    check("mid_pre_busy", busy_mask, 32'h0000_0010);
    rst_n = 1'b0; settle();
    check("mid_rst_wen", {31'd0, rf_wen}, 32'd0);
    check("mid_rst_busy", busy_mask, 32'd0);
    #4 rst_n = 1'b1;
    step();
    check("post_rst_mem_ready", {31'd0, mem_ready}, 32'd1);
    check("post_rst_wen", {31'd0, rf_wen}, 32'd0);

    step();
    check("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
